icache_assoc: RTL

Parametrised set-associative instruction cache, the next generation of the direct-mapped icache.
- Sits between the datapath fetch port (datapath_cache_if.icache modport) and the memory-control instruction port (caches_if.icache modport).
- Adds configurable sets, ways and words per block, LRU replacement, a multi-word refill that is immune to address changes, fetch-gated misses, a full-cache flush and hit/miss counters.

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/caches_if.sv | 15 +
 rtl/datapath_cache_if.sv | 15 +
 rtl/icache_lru.sv | 33 +++
 rtl/icache_assoc.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the instruction-cache controller states.
// Latency: none (type definitions only).
// Backpressure: not applicable.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic {
    CHECK = 1'b0,
    FILL  = 1'b1
  } icache_state_t;
endpackage

// File: rtl/caches_if.sv
// Cache <-> memory-control interface (instruction side only).
// Latency: none; plain wires.
// Backpressure: memory stalls a read by holding iwait high.
//   icache modport: iREN, iaddr out; iwait, iload in
interface caches_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport icache (output iREN, iaddr, input iwait, iload);
  modport mem    (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/datapath_cache_if.sv
// Datapath <-> cache interface (instruction side only).
// Latency: none; plain wires.
// Backpressure: the cache holds ihit low until the requested word is present.
//   icache modport: imemREN, imemaddr in; ihit, imemload out
interface datapath_cache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport icache (input imemREN, imemaddr, output ihit, imemload);
  modport dp     (output imemREN, imemaddr, input ihit, imemload);
endinterface

// File: rtl/icache_lru.sv
// LRU age update and victim selection for one cache set.
// Latency: purely combinational.
// Backpressure: none.
//   ages/valid: the set's age vector and valid bits; touch: way to make MRU
//   ages_nxt: ages after the touch; victim: first invalid way, else the oldest way
module icache_lru #(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages,
  input  logic [WAYS-1:0]            valid,
  input  logic [WAY_W-1:0]           touch,
  output logic [WAYS-1:0][AGE_W-1:0] ages_nxt,
  output logic [WAY_W-1:0]           victim
);
  always_comb begin
    ages_nxt = ages;
    victim   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ages[w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    // Scanning downwards lets the lowest-numbered invalid way win over the oldest.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
    // Only ways younger than the touched one age, so the ages stay a permutation.
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == touch)         ages_nxt[w] = '0;
      else if (ages[w] < ages[touch]) ages_nxt[w] = ages[w] + AGE_W'(1);
    end
  end
endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with LRU replacement, multi-word refill and flush.
// Latency: hits combinational; a miss costs WORDS fill cycles plus any iwait cycles.
// Backpressure: ihit stays low while filling; the fill advances only when iwait=0.
//   CLK/RST: clock, async active-high reset; dcif: fetch port; ciif: memory port
//   iflush: invalidate all lines; hit_count/miss_count: wrapping hit-cycle/refill counters
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic             CLK,
  input  logic             RST,
  datapath_cache_if.icache dcif,
  caches_if.icache         ciif,
  input  logic             iflush,
  output word_t            hit_count,
  output word_t            miss_count
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_W = AGE_W;
  localparam int K_W   = (WORDS > 1) ? OFF_W : 1;

  // bofs holds word offset plus the ignored byte offset.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W+1:0] bofs;
  } addr_t;

  // Valid bits live in their own reset array; the frame carries tag and data.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    word_t [WORDS-1:0] data;
  } frame_t;

  icache_state_t                          state;
  logic [K_W-1:0]                         k;
  addr_t                                  base;
  logic [WAY_W-1:0]                       victim_q;
  logic                                   flush_pend;
  word_t [WORDS-1:0]                      lbuf;
  logic [SETS-1:0][WAYS-1:0]              valid_q;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]   ages_q;
  frame_t                                 frames_q [SETS][WAYS];

  addr_t                      req;
  logic [K_W-1:0]             wofs;
  logic [WAYS-1:0]            match;
  logic                       hit_any;
  logic [WAY_W-1:0]           hit_way;
  logic [IDX_W-1:0]           lru_idx;
  logic [WAY_W-1:0]           lru_touch;
  logic [WAYS-1:0][AGE_W-1:0] ages_nxt;
  logic [WAY_W-1:0]           victim;
  logic                       last;
  word_t [WORDS-1:0]          fill_data;
  frame_t                     hit_frame;

  assign req  = addr_t'(dcif.imemaddr);
  assign wofs = K_W'(req.bofs >> 2);
  assign last = (int'(k) == WORDS - 1);

  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[req.idx][w] && (frames_q[req.idx][w].tag == req.tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit_any   = |match;
  assign hit_frame = frames_q[req.idx][hit_way];

  assign dcif.ihit     = (state == CHECK) && dcif.imemREN && !iflush && hit_any;
  assign dcif.imemload = hit_frame.data[wofs];
  assign ciif.iREN     = (state == FILL);
  assign ciif.iaddr    = (state == FILL) ? (word_t'(base) | (word_t'(k) << 2)) : word_t'(req);

  // During FILL the LRU unit serves the latched set so the final touch hits the victim way.
  assign lru_idx   = (state == FILL) ? base.idx : req.idx;
  assign lru_touch = (state == FILL) ? victim_q : hit_way;

  icache_lru #(.WAYS(WAYS), .AGE_W(AGE_W), .WAY_W(WAY_W)) u_lru (
    .ages     (ages_q[lru_idx]),
    .valid    (valid_q[lru_idx]),
    .touch    (lru_touch),
    .ages_nxt (ages_nxt),
    .victim   (victim)
  );

  // The last word goes straight from iload into the line, bypassing the buffer.
  always_comb begin
    fill_data    = lbuf;
    fill_data[k] = ciif.iload;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= CHECK;
      k          <= '0;
      base       <= '0;
      victim_q   <= '0;
      flush_pend <= 1'b0;
      lbuf       <= '0;
      valid_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) ages_q[s][w] <= AGE_W'(w);
      end
    end else begin
      case (state)
        CHECK: begin
          if (iflush) begin
            valid_q <= '0;
          end else if (dcif.imemREN) begin
            if (hit_any) begin
              ages_q[req.idx] <= ages_nxt;
              hit_count       <= hit_count + 32'd1;
            end else begin
              base       <= '{tag: req.tag, idx: req.idx, bofs: '0};
              victim_q   <= victim;
              miss_count <= miss_count + 32'd1;
              k          <= '0;
              state      <= FILL;
            end
          end
        end
        FILL: begin
          if (iflush) flush_pend <= 1'b1;
          if (!ciif.iwait) begin
            lbuf[k] <= ciif.iload;
            if (last) begin
              state            <= CHECK;
              k                <= '0;
              flush_pend       <= 1'b0;
              ages_q[base.idx] <= ages_nxt;
              // A flush seen at any point of the fill also wipes the line just written.
              if (flush_pend || iflush) valid_q <= '0;
              else                      valid_q[base.idx][victim_q] <= 1'b1;
            end else begin
              k <= k + K_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Tag/data storage needs no reset: nothing is visible without its valid bit.
  always_ff @(posedge CLK) begin
    if (state == FILL && !ciif.iwait && last)
      frames_q[base.idx][victim_q] <= '{tag: base.tag, data: fill_data};
  end
endmodule
